led_seq_driver: RTL and testbench

Parametrised LED sequencer that replaces the fixed 8-LED heartbeat chaser. It supports configurable LED count and on/off phase lengths, and adds four run-time selectable patterns: forward, reverse, bounce and all-blink. It also has an enable/pause input and a one-cycle sequence-wrap strobe. It sits under the LED mode mux and drives the board LED bank directly, with one instance per selectable display mode.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_phase_timer.sv | 24 ++
 rtl/led_seq_driver.sv | 156 +++++++++++++++
 tb/tb_led_seq_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED display types: pattern modes and sequencer FSM states.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_FWD    = 2'd0,
    MODE_REV    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } led_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } led_state_t;

endpackage

// File: rtl/led_phase_timer.sv
// Terminal-count phase timer: done is high while the count equals limit.
module led_phase_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign done = (r_cnt == limit);

endmodule

// File: rtl/led_seq_driver.sv
// Parametrised LED sequencer: forward/reverse/bounce/all-blink patterns with
// configurable on/off phase lengths, pause input and pattern-pass strobe.
module led_seq_driver
  import led_pkg::*;
#(
  parameter int unsigned LED_COUNT  = 8,
  parameter int unsigned ON_CYCLES  = 1200,
  parameter int unsigned OFF_CYCLES = 1200,
  localparam int unsigned CNT_W =
    $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) + 1),
  localparam int unsigned IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  output logic [LED_COUNT-1:0] led_out,
  output logic [IDX_W-1:0]     led_idx,
  output logic                 cycle_done
);

  localparam logic [CNT_W-1:0] ON_LIM   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LIM  = (OFF_CYCLES == 0) ? '0 : CNT_W'(OFF_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LED_COUNT - 1);

  led_state_t           r_state;
  led_mode_t            r_mode;
  logic                 r_dir_up;
  logic [IDX_W-1:0]     r_idx;
  logic [LED_COUNT-1:0] r_led;
  logic                 r_done;

  led_mode_t            w_mode_in;
  logic [CNT_W-1:0]     w_limit;
  logic                 w_phase_done;
  logic                 w_clear;
  logic                 w_step;
  logic [IDX_W-1:0]     w_nxt_idx;
  logic                 w_nxt_dir;
  logic                 w_wrap;

  function automatic logic [LED_COUNT-1:0] f_pattern(input logic [IDX_W-1:0] idx,
                                                     input led_mode_t m);
    logic [LED_COUNT-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < LED_COUNT; i++) begin
      v[i] = (m == MODE_BLINK) || (idx == IDX_W'(i));
    end
    return v;
  endfunction

  assign w_mode_in = led_mode_t'(mode);
  assign w_limit   = (r_state == ST_OFF) ? OFF_LIM : ON_LIM;
  // Every terminal count in ON/OFF enters a new phase, so it always restarts the counter.
  assign w_clear   = !enable || (r_state == ST_IDLE) || w_phase_done;
  assign w_step    = enable && w_phase_done &&
                     ((r_state == ST_OFF) || ((r_state == ST_ON) && (OFF_CYCLES == 0)));

  led_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .limit(w_limit),
    .done (w_phase_done)
  );

  always_comb begin
    w_nxt_idx = r_idx;
    w_nxt_dir = r_dir_up;
    w_wrap    = 1'b0;
    if (LED_COUNT == 1) begin
      w_nxt_idx = '0;
      w_wrap    = 1'b1;
    end else begin
      case (w_mode_in)
        MODE_FWD: begin
          if (r_idx == LAST_IDX) begin
            w_nxt_idx = '0;
            w_wrap    = 1'b1;
          end else begin
            w_nxt_idx = r_idx + IDX_W'(1);
          end
        end
        MODE_REV: begin
          if (r_idx == '0) begin
            w_nxt_idx = LAST_IDX;
            w_wrap    = 1'b1;
          end else begin
            w_nxt_idx = r_idx - IDX_W'(1);
          end
        end
        MODE_BOUNCE: begin
          if (r_dir_up) begin
            if (r_idx == LAST_IDX) begin
              w_nxt_idx = LAST_IDX - IDX_W'(1);
              w_nxt_dir = 1'b0;
              w_wrap    = 1'b1;
            end else begin
              w_nxt_idx = r_idx + IDX_W'(1);
            end
          end else begin
            if (r_idx == '0) begin
              w_nxt_idx = IDX_W'(1);
              w_nxt_dir = 1'b1;
              w_wrap    = 1'b1;
            end else begin
              w_nxt_idx = r_idx - IDX_W'(1);
            end
          end
        end
        default: w_wrap = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_FWD;
      r_dir_up <= 1'b1;
      r_idx    <= '0;
      r_led    <= '0;
      r_done   <= 1'b0;
    end else if (!enable) begin
      r_state <= ST_IDLE;
      r_led   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_state <= ST_ON;
        r_mode  <= w_mode_in;
        r_led   <= f_pattern(r_idx, w_mode_in);
      end else if (w_step) begin
        r_state  <= ST_ON;
        r_mode   <= w_mode_in;
        r_idx    <= w_nxt_idx;
        r_dir_up <= w_nxt_dir;
        r_led    <= f_pattern(w_nxt_idx, w_mode_in);
        r_done   <= w_wrap;
      end else if ((r_state == ST_ON) && w_phase_done) begin
        r_state <= ST_OFF;
        r_led   <= '0;
      end else if (r_state == ST_ON) begin
        r_led <= f_pattern(r_idx, r_mode);
      end
    end
  end

  assign led_out    = r_led;
  assign led_idx    = r_idx;
  assign cycle_done = r_done;

endmodule

// File: tb/tb_led_seq_driver.sv
// Directed self-checking bench for led_seq_driver across three parameter sets.
module tb_led_seq_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // A: 8 LEDs, ON=4, OFF=2
  logic       rst_a, en_a, done_a;
  logic [1:0] mode_a;
  logic [7:0] led_a;
  logic [2:0] idx_a;
  // B: 4 LEDs, ON=1, OFF=0
  logic       rst_b, en_b, done_b;
  logic [1:0] mode_b;
  logic [3:0] led_b;
  logic [1:0] idx_b;
  // C: 1 LED, ON=2, OFF=0
  logic       rst_c, en_c, done_c;
  logic [1:0] mode_c;
  logic [0:0] led_c;
  logic [0:0] idx_c;

  led_seq_driver #(.LED_COUNT(8), .ON_CYCLES(4), .OFF_CYCLES(2)) u_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .mode(mode_a),
    .led_out(led_a), .led_idx(idx_a), .cycle_done(done_a));

  led_seq_driver #(.LED_COUNT(4), .ON_CYCLES(1), .OFF_CYCLES(0)) u_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .mode(mode_b),
    .led_out(led_b), .led_idx(idx_b), .cycle_done(done_b));

  led_seq_driver #(.LED_COUNT(1), .ON_CYCLES(2), .OFF_CYCLES(0)) u_c (
    .clk(clk), .rst(rst_c), .enable(en_c), .mode(mode_c),
    .led_out(led_c), .led_idx(idx_c), .cycle_done(done_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] b_idx [9];
    logic       b_done[9];
    logic [1:0] r_idx [4];
    logic       r_done[4];
    b_idx  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
    b_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    r_idx  = '{2'd1, 2'd0, 2'd3, 2'd2};
    r_done = '{1'b0, 1'b0, 1'b1, 1'b0};

    rst_a = 1'b1; en_a = 1'b1; mode_a = 2'd0;
    rst_b = 1'b1; en_b = 1'b1; mode_b = 2'd2;
    rst_c = 1'b1; en_c = 1'b1; mode_c = 2'd0;
    tick();
    tick();
    check("a_rst_led",  32'(led_a),  32'h0);
    check("a_rst_idx",  32'(idx_a),  32'h0);
    check("a_rst_done", 32'(done_a), 32'h0);
    check("b_rst_led",  32'(led_b),  32'h0);
    check("c_rst_led",  32'(led_c),  32'h0);

    // Basic forward chase
    rst_a = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (e <= 4)       check("a_basic_on0",  32'(led_a), 32'h01);
      else if (e <= 6)  check("a_basic_off0", 32'(led_a), 32'h00);
      else if (e <= 10) check("a_basic_on1",  32'(led_a), 32'h02);
      if (e == 7)  check("a_nowrap_done", 32'(done_a), 32'h0);
      if (e == 43) check("a_led7", 32'(led_a), 32'h80);
      if (e == 49) begin
        check("a_wrap_led",  32'(led_a),  32'h01);
        check("a_wrap_done", 32'(done_a), 32'h1);
      end
      if (e == 50) check("a_wrap_done_clr", 32'(done_a), 32'h0);
    end

    // Mode change mid-phase: at edge 80 idx 5 is lit
    repeat (30) tick();
    check("a_mc_idx5", 32'(idx_a), 32'd5);
    check("a_mc_led5", 32'(led_a), 32'h20);
    mode_a = 2'd1;
    repeat (4) tick();
    check("a_mc_hold_idx", 32'(idx_a), 32'd5);
    check("a_mc_hold_led", 32'(led_a), 32'h00);
    tick();
    check("a_mc_rev_idx",  32'(idx_a),  32'd4);
    check("a_mc_rev_led",  32'(led_a),  32'h10);
    check("a_mc_rev_done", 32'(done_a), 32'h0);
    repeat (30) tick();
    check("a_rev_wrap_idx",  32'(idx_a),  32'd7);
    check("a_rev_wrap_led",  32'(led_a),  32'h80);
    check("a_rev_wrap_done", 32'(done_a), 32'h1);

    // Pause during OFF at idx 3, then resume
    repeat (28) tick();
    check("a_pz_off_idx", 32'(idx_a), 32'd3);
    check("a_pz_off_led", 32'(led_a), 32'h00);
    en_a = 1'b0;
    tick();
    check("a_pz_led",  32'(led_a),  32'h00);
    check("a_pz_idx",  32'(idx_a),  32'd3);
    check("a_pz_done", 32'(done_a), 32'h0);
    repeat (3) tick();
    check("a_pz_hold_idx", 32'(idx_a), 32'd3);
    check("a_pz_hold_led", 32'(led_a), 32'h00);
    en_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("a_resume_on", 32'(led_a), 32'h08);
    end
    tick();
    check("a_resume_off", 32'(led_a), 32'h00);
    tick();
    tick();
    check("a_resume_adv_idx", 32'(idx_a), 32'd2);
    check("a_resume_adv_led", 32'(led_a), 32'h04);

    // Synchronous reset mid-ON at idx 6
    rst_a = 1'b1;
    tick();
    check("a_rst2_led", 32'(led_a), 32'h00);
    check("a_rst2_idx", 32'(idx_a), 32'd0);
    mode_a = 2'd0;
    rst_a = 1'b0;
    for (int e = 1; e <= 38; e++) begin
      tick();
      if (e == 1) check("a_restart_led", 32'(led_a), 32'h01);
      if (e == 37 || e == 38) begin
        check("a_pre_rst_idx", 32'(idx_a), 32'd6);
        check("a_pre_rst_led", 32'(led_a), 32'h40);
      end
    end
    rst_a = 1'b1;
    tick();
    check("a_midrst_led",  32'(led_a),  32'h00);
    check("a_midrst_idx",  32'(idx_a),  32'd0);
    check("a_midrst_done", 32'(done_a), 32'h0);
    tick();
    check("a_midrst_hold", 32'(led_a), 32'h00);
    rst_a = 1'b0;
    tick();
    check("a_post_rst_led", 32'(led_a), 32'h01);
    check("a_post_rst_idx", 32'(idx_a), 32'd0);

    // All-blink: mode change takes effect only at the next advance
    mode_a = 2'd3;
    for (int e = 2; e <= 13; e++) begin
      tick();
      if (e <= 4)                    check("a_blk_old",  32'(led_a), 32'h01);
      else if (e <= 6 || e >= 11 && e <= 12) check("a_blk_dark", 32'(led_a), 32'h00);
      else                           check("a_blk_lit",  32'(led_a), 32'hFF);
      check("a_blk_idx", 32'(idx_a), 32'd0);
      check("a_blk_done", 32'(done_a), (e == 7 || e == 13) ? 32'h1 : 32'h0);
    end

    // Bounce on 4 LEDs, one clock per LED
    rst_b = 1'b0;
    for (int e = 0; e < 9; e++) begin
      tick();
      check("b_bnc_idx",  32'(idx_b),  32'(b_idx[e]));
      check("b_bnc_led",  32'(led_b),  32'(1) << b_idx[e]);
      check("b_bnc_done", 32'(done_b), 32'(b_done[e]));
    end
    mode_b = 2'd1;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("b_rev_idx",  32'(idx_b),  32'(r_idx[e]));
      check("b_rev_done", 32'(done_b), 32'(r_done[e]));
    end

    // Single LED: lit throughout, strobe every second clock
    rst_c = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("c_led",  32'(led_c),  32'h1);
      check("c_idx",  32'(idx_c),  32'h0);
      check("c_done", 32'(done_c), (e >= 3 && (e % 2) == 1) ? 32'h1 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
